pps_period_reporter: RTL and testbench
======================================

Name: pps_period_reporter

Overview:
- Sits directly upstream of the UART transmitter in the top-level UART design; consumes the raw PPS pin and produces the byte stream the transmitter sends on serial_txd.
- Synchronises the PPS input, counts clk12 cycles between consecutive PPS rising edges, and emits each measured period as an ASCII line: CNT_W/4 uppercase hex digits followed by CR LF, via a valid/ready byte interface.

Parameters:
- CNT_W, 32, period counter width; multiple of 4, range 8..32.
- SYNC_STAGES, 2, synchroniser flops on pps_i; minimum 2.
- FILTER_LEN, 4, stable-sample count for the glitch filter; used only when PPS_GLITCH_FILTER_EN is defined.

Ports:
- clk12  input  1  system clock (12 MHz).
- rst  input  1  synchronous, active-high reset.
- pps_i  input  1  asynchronous PPS pin.
- tx_data  output  8  ASCII byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte this cycle.
- pps_pulse  output  1  one-cycle strobe on each detected rising edge.
- period  output  CNT_W  last latched period in cycles.
- busy  output  1  line transmission in progress.
- overrun  output  1  sticky: a period was dropped.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, pps_pulse=0, period=0, busy=0, overrun=0. Counter=0, first_seen=0, pending empty, FSM=IDLE.
- Edge detect: SYNC_STAGES flops, then a registered compare. pps_pulse is high exactly one cycle, SYNC_STAGES+1 cycles after pps_i rises. No pulse for a level that is high out of reset.
- Counter: increments every cycle and saturates at 2^CNT_W-1. On the pps_pulse cycle it latches into period, then loads 1. Edges at cycles t0 and t1 therefore give period=t1-t0.
- First edge after reset only sets first_seen. No line is emitted, and period is not updated.
- Each later edge places period into a 1-deep pending buffer. If the buffer is already full, the new value is dropped and overrun is set; overrun clears only on rst. period itself is still updated.
- FSM states: IDLE, DIGIT, CR, LF.
  - IDLE: if pending is full, move it into the shift register, clear pending, set digit index to CNT_W/4-1, and go to DIGIT. tx_valid rises on the next cycle.
  - DIGIT: tx_data is the ASCII of the indexed nibble ('0'-'9', 'A'-'F'). On tx_valid&&tx_ready: at index 0 go to CR, otherwise decrement the index.
  - CR: tx_data=8'h0D; on handshake go to LF.
  - LF: tx_data=8'h0A; on handshake go to IDLE and drop tx_valid the same cycle unless pending is full. If pending is full, the next line starts without a gap.
- Handshake: while tx_valid&&!tx_ready, tx_data and tx_valid are held stable. tx_valid never drops without a handshake (except on rst).
- busy is high in DIGIT, CR and LF.
- Simultaneous edge and line completion: latching into pending takes priority; no overrun occurs because pending was already empty at line start.
- A saturated count is reported as all-F digits.
- rst mid-line: the line is abandoned immediately and tx_valid=0 on the next cycle.

Optional Feature:
- Macro PPS_GLITCH_FILTER_EN.
- Defined: after synchronisation, the filtered level changes only after FILTER_LEN consecutive equal samples. Edge latency becomes SYNC_STAGES+FILTER_LEN+1 cycles. Pulses shorter than FILTER_LEN cycles are ignored.
- Undefined: no filter, and latency is SYNC_STAGES+1.

Decomposition:
- Package easy_uart_pkg: ASCII_CR, ASCII_LF, ASCII_0, ASCII_A constants; FSM state encoding; nibble-to-hex-ASCII function.
- Sub-module pps_sync_edge: synchroniser, optional glitch filter, and rising-edge detector. Outputs pps_pulse.

Test Plan:
- Edges 1000 cycles apart, tx_ready held 1 → first edge gives no output. Second edge gives the byte sequence "000003E8" then 0D 0A, with period=32'h3E8 and pps_pulse width 1.
- Same stimulus with tx_ready asserted only every 7th cycle → identical bytes; tx_data stays stable across every stall.
- Edges 20 cycles apart, tx_ready held 0 for 200 cycles → first line holds at '0', pending holds 20, the third later edge sets overrun=1. After release, lines "00000014" and "00000014" are emitted and overrun stays 1.
- CNT_W=8, edges 300 cycles apart → line "FF\r\n" (saturated).
- rst asserted after the 3rd byte of a line → tx_valid=0 and busy=0 next cycle. The next edge after reset emits nothing (first_seen cleared).
- PPS_GLITCH_FILTER_EN defined, 2-cycle glitch between valid edges 500 apart → no pps_pulse for the glitch; line "000001F4\r\n".

Source files
------------

// File: rtl/easy_uart_pkg.sv
// Shared constants, FSM state encoding and hex-digit helper for the PPS
// period reporter that feeds the UART transmitter.
package easy_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } tx_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'd0, nib};
    else             return ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// PPS synchroniser, optional glitch filter (PPS_GLITCH_FILTER_EN) and
// rising-edge detector producing a one-cycle pps_pulse.
module pps_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk12,
  input  logic rst,
  input  logic pps_i,
  output logic pps_pulse
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;
  logic                   prev_p1;

  // Stage 0: metastability chain on the asynchronous pin
  always_ff @(posedge clk12) begin
    sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pps_i};
  end

`ifdef PPS_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILTER_LEN) + 1;
  logic [FC_W-1:0] stab_cnt;

  // Stage 1: level only follows after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk12) begin
    if (rst) begin
      lvl_p1   <= 1'b1;
      stab_cnt <= '0;
    end else if (sync_p0[SYNC_STAGES-1] == lvl_p1) begin
      stab_cnt <= '0;
    end else if (stab_cnt == FC_W'(FILTER_LEN - 1)) begin
      lvl_p1   <= sync_p0[SYNC_STAGES-1];
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end
`else
  assign lvl_p1 = sync_p0[SYNC_STAGES-1];
`endif

  // Stage 2: edge compare; prev held high in reset so a pin already high is not an edge
  always_ff @(posedge clk12) begin
    if (rst) begin
      prev_p1   <= 1'b1;
      pps_pulse <= 1'b0;
    end else begin
      prev_p1   <= lvl_p1;
      pps_pulse <= lvl_p1 & ~prev_p1;
    end
  end

endmodule

// File: rtl/pps_period_reporter.sv
// Measures clk12 cycles between PPS rising edges and streams each period as
// uppercase hex + CR LF on a valid/ready byte port. Macro: PPS_GLITCH_FILTER_EN.
module pps_period_reporter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk12,
  input  logic             rst,
  input  logic             pps_i,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             pps_pulse,
  output logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             overrun
);
  import easy_uart_pkg::*;

  localparam int DIGITS = CNT_W / 4;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_val;
  logic             pend_full;
  logic             first_seen;
  logic             pend_take;
  logic             hs;
  logic [CNT_W-5:0] shreg;
  logic [IDX_W-1:0] idx;
  tx_state_t        state;

  pps_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_edge (
    .clk12    (clk12),
    .rst      (rst),
    .pps_i    (pps_i),
    .pps_pulse(pps_pulse)
  );

  assign hs        = tx_valid & tx_ready;
  // A line starts from IDLE, or back-to-back straight out of the LF handshake
  assign pend_take = pend_full && ((state == IDLE) || (state == LF && hs));

  always_ff @(posedge clk12) begin
    if (rst) begin
      cnt        <= '0;
      period     <= '0;
      pend_val   <= '0;
      pend_full  <= 1'b0;
      first_seen <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (pend_take) pend_full <= 1'b0;
      if (pps_pulse) begin
        cnt        <= {{(CNT_W-1){1'b0}}, 1'b1};
        first_seen <= 1'b1;
        if (first_seen) begin
          period <= cnt;
          if (pend_full && !pend_take) begin
            overrun <= 1'b1;
          end else begin
            pend_val  <= cnt;
            pend_full <= 1'b1;
          end
        end
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk12) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      shreg    <= '0;
      idx      <= '0;
    end else if (pend_take) begin
      state    <= DIGIT;
      shreg    <= pend_val[CNT_W-5:0];
      idx      <= IDX_W'(DIGITS - 1);
      tx_data  <= hex_ascii(pend_val[CNT_W-1 -: 4]);
      tx_valid <= 1'b1;
      busy     <= 1'b1;
    end else begin
      case (state)
        DIGIT: if (hs) begin
          if (idx == '0) begin
            state   <= CR;
            tx_data <= ASCII_CR;
          end else begin
            idx     <= idx - 1'b1;
            shreg   <= shreg << 4;
            tx_data <= hex_ascii(shreg[CNT_W-5 -: 4]);
          end
        end
        CR: if (hs) begin
          state   <= LF;
          tx_data <= ASCII_LF;
        end
        LF: if (hs) begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pps_period_reporter.sv
// Scoreboard bench for pps_period_reporter: a 32-bit and an 8-bit instance.
module tb_pps_period_reporter;

  logic        clk12 = 1'b0;
  logic        rst, pps_a, pps_b, rdy_a, rdy_b;
  logic [7:0]  data_a, data_b;
  logic        valid_a, valid_b, pulse_a, pulse_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [31:0] period_a;
  logic [7:0]  period_b;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int pulses_a = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk12 = ~clk12;

  pps_period_reporter #(.CNT_W(32), .SYNC_STAGES(2), .FILTER_LEN(4)) dut_a (
    .clk12(clk12), .rst(rst), .pps_i(pps_a), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(rdy_a), .pps_pulse(pulse_a), .period(period_a), .busy(busy_a), .overrun(ovr_a)
  );

  pps_period_reporter #(.CNT_W(8), .SYNC_STAGES(2), .FILTER_LEN(4)) dut_b (
    .clk12(clk12), .rst(rst), .pps_i(pps_b), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(rdy_b), .pps_pulse(pulse_b), .period(period_b), .busy(busy_b), .overrun(ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    string s;
    s = "0123456789ABCDEF";
    return s[n];
  endfunction

  task automatic push_line_a(input logic [31:0] v);
    for (int i = 7; i >= 0; i--) exp_a.push_back(asc(v[i*4 +: 4]));
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  task automatic push_line_b(input logic [7:0] v);
    exp_b.push_back(asc(v[7:4]));
    exp_b.push_back(asc(v[3:0]));
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk12);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    pulses_a = 0;
  endtask

  task automatic edges_a(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      pps_a = 1'b1; cyc(10);
      pps_a = 1'b0; cyc(gap - 10);
    end
  endtask

  task automatic edges_b(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      pps_b = 1'b1; cyc(10);
      pps_b = 1'b0; cyc(gap - 10);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, exp_a.size() + exp_b.size(), 0);
  endtask

  // Ready pattern generator
  initial begin
    int c;
    c = 0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    forever begin
      @(posedge clk12); #1;
      c++;
      case (rdy_mode)
        0:       rdy_a = 1'b1;
        1:       rdy_a = (c % 7 == 0);
        default: rdy_a = 1'b0;
      endcase
    end
  end

  // Monitor A: byte scoreboard, stall stability, pulse width
  initial begin
    logic       stall;
    logic [7:0] hold, e;
    int         run;
    stall = 1'b0; hold = '0; run = 0;
    forever begin
      @(negedge clk12);
      if (stall) begin
        check("stall_valid_a", valid_a, 1);
        check("stall_data_a", data_a, hold);
      end
      if (valid_a && rdy_a) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte_a actual=%02h required=none", data_a);
        end else begin
          e = exp_a.pop_front();
          check("byte_a", data_a, e);
        end
      end
      if (pulse_a) begin
        if (run == 0) pulses_a++;
        run++;
      end else if (run != 0) begin
        check("pulse_width_a", run, 1);
        run = 0;
      end
      stall = valid_a && !rdy_a && !rst;
      hold  = data_a;
    end
  end

  // Monitor B: byte scoreboard for the 8-bit instance
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk12);
      if (valid_b && rdy_b) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte_b actual=%02h required=none", data_b);
        end else begin
          e = exp_b.pop_front();
          check("byte_b", data_b, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    rst = 1'b1; pps_a = 1'b0; pps_b = 1'b0;
    cyc(2);

    // Reset state
    do_reset();
    check("rst_tx_data", data_a, 0);
    check("rst_tx_valid", valid_a, 0);
    check("rst_pps_pulse", pulse_a, 0);
    check("rst_period", period_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_overrun", ovr_a, 0);
    cyc(20);

    // 1000-cycle period, ready always high
    do_reset();
    rdy_mode = 0;
    push_line_a(32'd1000);
    edges_a(2, 1000);
    drain("drain_t1", 300);
    check("period_t1", period_a, 32'h3E8);
    check("pulses_t1", pulses_a, 2);
    check("overrun_t1", ovr_a, 0);

    // Same with ready only every 7th cycle
    do_reset();
    rdy_mode = 1;
    push_line_a(32'd1000);
    edges_a(2, 1000);
    drain("drain_t2", 300);
    check("period_t2", period_a, 32'h3E8);

    // Ready held low: pending fills, then overrun
    do_reset();
    rdy_mode = 2;
    push_line_a(32'd20);
    push_line_a(32'd20);
    edges_a(4, 20);
    check("overrun_set_t3", ovr_a, 1);
    check("held_valid_t3", valid_a, 1);
    check("held_data_t3", data_a, 32'h30);
    check("busy_t3", busy_a, 1);
    check("period_t3", period_a, 20);
    cyc(120);
    rdy_mode = 0;
    drain("drain_t3", 300);
    check("overrun_sticky_t3", ovr_a, 1);

    // CNT_W=8 saturation
    do_reset();
    push_line_b(8'hFF);
    edges_b(2, 300);
    drain("drain_t4", 100);
    check("period_sat_t4", period_b, 8'hFF);

    // Reset mid-line after the third byte
    do_reset();
    rdy_mode = 0;
    exp_a.push_back(8'h30); exp_a.push_back(8'h30); exp_a.push_back(8'h30);
    edges_a(1, 1000);
    pps_a = 1'b1;
    n = 0; t = 0;
    while (n < 3 && t < 100) begin
      @(negedge clk12);
      t++;
      if (valid_a && rdy_a) n++;
    end
    rst = 1'b1;
    check("bytes_before_rst_t5", n, 3);
    @(posedge clk12); #1;
    rst = 1'b0;
    check("valid_after_rst_t5", valid_a, 0);
    check("busy_after_rst_t5", busy_a, 0);
    cyc(10);
    pps_a = 1'b0;
    cyc(20);
    edges_a(1, 100);
    cyc(50);
    check("period_after_rst_t5", period_a, 0);
    check("busy_idle_t5", busy_a, 0);
    check("queue_empty_t5", exp_a.size(), 0);

`ifdef PPS_GLITCH_FILTER_EN
    // Short glitch between valid edges must be filtered out
    do_reset();
    rdy_mode = 0;
    push_line_a(32'd500);
    pps_a = 1'b1; cyc(10); pps_a = 1'b0; cyc(240);
    pps_a = 1'b1; cyc(2);  pps_a = 1'b0; cyc(248);
    pps_a = 1'b1; cyc(10); pps_a = 1'b0; cyc(240);
    drain("drain_t6", 300);
    check("pulses_t6", pulses_a, 2);
    check("period_t6", period_a, 32'h1F4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
